tx_data_send_buf: RTL and testbench

Parametrised successor to the SpaceWire TX staging logic. It replaces the two-entry ping-pong holding registers with a DEPTH-entry first-word-fall-through FIFO and replaces the single fct_counter_p flag with a full FCT credit counter. It also holds a pending time-code until the encoder accepts it. The block sits between the host write interface and the TX character encoder, in the pclk_tx domain.

---
 rtl/tx_send_pkg.sv | 15 +
 rtl/tx_send_fifo.sv | 53 +++++
 rtl/tx_data_send_buf.sv | 88 ++++++++
 tb/tb_tx_data_send_buf.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_send_pkg.sv
// Shared constants for the SpaceWire TX staging path: credit sizing and the
// N-char control-flag encoding.
package tx_send_pkg;

  localparam int unsigned FCT_CREDIT_INC = 8;
  localparam int unsigned CREDIT_MAX_DEF = 56;
  localparam int unsigned DATA_W_DEF     = 9;
  localparam int unsigned CTRL_BIT       = DATA_W_DEF - 1;

  typedef enum logic [1:0] {
    CTRL_EOP = 2'b00,
    CTRL_EEP = 2'b01
  } ctrl_code_e;

endpackage

// File: rtl/tx_send_fifo.sv
// First-word-fall-through FIFO; the head is visible on rd_data whenever the FIFO
// is non-empty and reads as zero when it is empty.
module tx_send_fifo #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     pclk_tx,
  input  logic                     enable_tx,
  input  logic                     wr_req,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = wr_req & ~full;
  assign rd_en   = rd_req & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge pclk_tx) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tx_data_send_buf.sv
// TX staging between host writes and the character encoder: N-char FIFO,
// FCT credit accounting and a single pending time-code slot.
module tx_data_send_buf
  import tx_send_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int unsigned CREDIT_W   = 6
) (
  input  logic                   pclk_tx,
  input  logic                   enable_tx,
  input  logic                   txwrite_tx,
  input  logic [DATA_W-1:0]      data_tx_i,
  output logic                   txrdy_tx,
  input  logic                   fct_rx,
  output logic [DATA_W-1:0]      tx_data_out,
  output logic                   tx_data_vld,
  input  logic                   tx_data_take,
  input  logic                   tickin_tx,
  input  logic [7:0]             timecode_tx_i,
  output logic [7:0]             tx_tcode_in,
  output logic                   tcode_rdy_trnsp,
  input  logic                   tcode_take,
  output logic [CREDIT_W-1:0]    credit_cnt,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   credit_err
);

  localparam int unsigned SW = CREDIT_W + 4;

  logic          fifo_full;
  logic          fifo_empty;
  logic          take;
  logic [SW-1:0] credit_sum;
  logic          credit_ovf;

  assign txrdy_tx    = enable_tx & ~fifo_full;
  assign tx_data_vld = ~fifo_empty & (credit_cnt != '0);
  assign take        = tx_data_take & tx_data_vld;

  tx_send_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .pclk_tx   (pclk_tx),
    .enable_tx (enable_tx),
    .wr_req    (txwrite_tx),
    .wr_data   (data_tx_i),
    .rd_req    (take),
    .rd_data   (tx_data_out),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Overflow is judged on the net update, so an FCT that arrives with a take
  // is tested against +7 rather than +8.
  always_comb begin
    credit_sum = SW'(credit_cnt) + (fct_rx ? SW'(FCT_CREDIT_INC) : '0);
    credit_ovf = (credit_sum - SW'(take)) > SW'(CREDIT_MAX);
  end

  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      credit_cnt <= '0;
      credit_err <= 1'b0;
    end else if (credit_ovf) begin
      credit_cnt <= credit_cnt - CREDIT_W'(take);
      credit_err <= 1'b1;
    end else begin
      credit_cnt <= credit_sum[CREDIT_W-1:0] - CREDIT_W'(take);
    end
  end

  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      tx_tcode_in     <= '0;
      tcode_rdy_trnsp <= 1'b0;
    end else if (tickin_tx) begin
      tx_tcode_in     <= timecode_tx_i;
      tcode_rdy_trnsp <= 1'b1;
    end else if (tcode_take) begin
      tcode_rdy_trnsp <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_data_send_buf.sv
// Directed bench for tx_data_send_buf: FIFO ordering, credit accounting,
// overflow, time-code slot and asynchronous reset.
module tb_tx_data_send_buf;

  logic       pclk_tx = 1'b0;
  logic       enable_tx;
  logic       txwrite_tx;
  logic [8:0] data_tx_i;
  logic       txrdy_tx;
  logic       fct_rx;
  logic [8:0] tx_data_out;
  logic       tx_data_vld;
  logic       tx_data_take;
  logic       tickin_tx;
  logic [7:0] timecode_tx_i;
  logic [7:0] tx_tcode_in;
  logic       tcode_rdy_trnsp;
  logic       tcode_take;
  logic [5:0] credit_cnt;
  logic [2:0] fifo_count;
  logic       credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  tx_data_send_buf #(
    .DATA_W     (9),
    .DEPTH      (4),
    .CREDIT_MAX (56),
    .CREDIT_W   (6)
  ) dut (
    .pclk_tx         (pclk_tx),
    .enable_tx       (enable_tx),
    .txwrite_tx      (txwrite_tx),
    .data_tx_i       (data_tx_i),
    .txrdy_tx        (txrdy_tx),
    .fct_rx          (fct_rx),
    .tx_data_out     (tx_data_out),
    .tx_data_vld     (tx_data_vld),
    .tx_data_take    (tx_data_take),
    .tickin_tx       (tickin_tx),
    .timecode_tx_i   (timecode_tx_i),
    .tx_tcode_in     (tx_tcode_in),
    .tcode_rdy_trnsp (tcode_rdy_trnsp),
    .tcode_take      (tcode_take),
    .credit_cnt      (credit_cnt),
    .fifo_count      (fifo_count),
    .credit_err      (credit_err)
  );

  always #5 pclk_tx = ~pclk_tx;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge pclk_tx);
    #1;
  endtask

  task automatic idle_inputs();
    txwrite_tx    = 1'b0;
    data_tx_i     = '0;
    fct_rx        = 1'b0;
    tx_data_take  = 1'b0;
    tickin_tx     = 1'b0;
    timecode_tx_i = '0;
    tcode_take    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick();
    enable_tx = 1'b0;
    #2;
    enable_tx = 1'b1;
    tick();
  endtask

  task automatic write_word(input logic [8:0] w);
    txwrite_tx = 1'b1;
    data_tx_i  = w;
    tick();
    txwrite_tx = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    enable_tx = 1'b0;
    tick();
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_checks++; if (credit_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_credit: got %0d want 0", credit_cnt); end
    n_checks++; if ({credit_err, tcode_rdy_trnsp, tx_data_vld, txrdy_tx} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {credit_err, tcode_rdy_trnsp, tx_data_vld, txrdy_tx}); end
    n_checks++; if ({tx_data_out, tx_tcode_in} !== 17'd0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {tx_data_out, tx_tcode_in}); end
    enable_tx = 1'b1;
    tick();
    n_checks++; if (txrdy_tx !== 1'b1) begin n_fail++; $display("FAIL rst_release_rdy: got %b want 1", txrdy_tx); end
  endtask

  task automatic test_stream();
    do_reset();
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    n_checks++; if (credit_cnt !== 6'd8) begin n_fail++; $display("FAIL str_credit8: got %0d want 8", credit_cnt); end
    write_word(9'h0A5);
    n_checks++; if (tx_data_out !== 9'h0A5 || tx_data_vld !== 1'b1) begin n_fail++; $display("FAIL str_w0: got %h/%b want 0a5/1", tx_data_out, tx_data_vld); end
    tx_data_take = 1'b1;
    write_word(9'h15A);
    n_checks++; if (tx_data_out !== 9'h15A || fifo_count !== 3'd1) begin n_fail++; $display("FAIL str_w1: got %h/%0d want 15a/1", tx_data_out, fifo_count); end
    write_word(9'h100);
    n_checks++; if (tx_data_out !== 9'h100 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL str_w2: got %h/%0d want 100/1", tx_data_out, fifo_count); end
    n_checks++; if (credit_cnt !== 6'd6) begin n_fail++; $display("FAIL str_credit6: got %0d want 6", credit_cnt); end
    tick();
    tx_data_take = 1'b0;
    n_checks++; if (credit_cnt !== 6'd5) begin n_fail++; $display("FAIL str_credit5: got %0d want 5", credit_cnt); end
    n_checks++; if (fifo_count !== 3'd0 || tx_data_vld !== 1'b0) begin n_fail++; $display("FAIL str_empty: got %0d/%b want 0/0", fifo_count, tx_data_vld); end
  endtask

  task automatic test_full_no_credit();
    logic [8:0] exp;
    do_reset();
    for (int i = 1; i <= 4; i++) write_word(9'(i));
    n_checks++; if (fifo_count !== 3'd4 || txrdy_tx !== 1'b0 || tx_data_vld !== 1'b0) begin n_fail++; $display("FAIL full_state: got %0d/%b/%b want 4/0/0", fifo_count, txrdy_tx, tx_data_vld); end
    write_word(9'h1FF);
    n_checks++; if (fifo_count !== 3'd4 || tx_data_out !== 9'h001) begin n_fail++; $display("FAIL full_drop: got %0d/%h want 4/001", fifo_count, tx_data_out); end
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    n_checks++; if (credit_cnt !== 6'd8 || tx_data_vld !== 1'b1) begin n_fail++; $display("FAIL full_fct: got %0d/%b want 8/1", credit_cnt, tx_data_vld); end
    tx_data_take = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = 9'(i);
      n_checks++; if (tx_data_out !== exp) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", i, tx_data_out, exp); end
      tick();
    end
    tx_data_take = 1'b0;
    n_checks++; if (credit_cnt !== 6'd4 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_end: got %0d/%0d want 4/0", credit_cnt, fifo_count); end
  endtask

  task automatic test_full_wr_take();
    logic [8:0] exp;
    do_reset();
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    for (int i = 0; i < 4; i++) write_word(9'h010 + 9'(i));
    tx_data_take = 1'b1;
    write_word(9'h077);
    n_checks++; if (fifo_count !== 3'd3 || credit_cnt !== 6'd7) begin n_fail++; $display("FAIL fwt_count: got %0d/%0d want 3/7", fifo_count, credit_cnt); end
    for (int i = 1; i < 4; i++) begin
      exp = 9'h010 + 9'(i);
      n_checks++; if (tx_data_out !== exp) begin n_fail++; $display("FAIL fwt_order_%0d: got %h want %h", i, tx_data_out, exp); end
      tick();
    end
    tx_data_take = 1'b0;
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL fwt_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    write_word(9'h0AA);
    fct_rx = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    fct_rx = 1'b0;
    n_checks++; if (credit_cnt !== 6'd56 || credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_56: got %0d/%b want 56/0", credit_cnt, credit_err); end
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    n_checks++; if (credit_cnt !== 6'd56 || credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_hit: got %0d/%b want 56/1", credit_cnt, credit_err); end
    fct_rx = 1'b1; tx_data_take = 1'b1; tick(); fct_rx = 1'b0; tx_data_take = 1'b0;
    n_checks++; if (credit_cnt !== 6'd55 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_take: got %0d/%0d want 55/0", credit_cnt, fifo_count); end
    tick();
    n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", credit_err); end
    do_reset();
    write_word(9'h055);
    fct_rx = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tx_data_take = 1'b1; tick(); fct_rx = 1'b0; tx_data_take = 1'b0;
    n_checks++; if (credit_cnt !== 6'd47 || credit_err !== 1'b0) begin n_fail++; $display("FAIL fct_take_47: got %0d/%b want 47/0", credit_cnt, credit_err); end
  endtask

  task automatic test_timecode();
    do_reset();
    tickin_tx = 1'b1; timecode_tx_i = 8'h3C; tick();
    n_checks++; if (tx_tcode_in !== 8'h3C || tcode_rdy_trnsp !== 1'b1) begin n_fail++; $display("FAIL tc_load: got %h/%b want 3c/1", tx_tcode_in, tcode_rdy_trnsp); end
    timecode_tx_i = 8'h3D; tick(); tickin_tx = 1'b0;
    n_checks++; if (tx_tcode_in !== 8'h3D || tcode_rdy_trnsp !== 1'b1) begin n_fail++; $display("FAIL tc_overwrite: got %h/%b want 3d/1", tx_tcode_in, tcode_rdy_trnsp); end
    tcode_take = 1'b1; tick(); tcode_take = 1'b0;
    n_checks++; if (tx_tcode_in !== 8'h3D || tcode_rdy_trnsp !== 1'b0) begin n_fail++; $display("FAIL tc_take: got %h/%b want 3d/0", tx_tcode_in, tcode_rdy_trnsp); end
    tickin_tx = 1'b1; tcode_take = 1'b1; timecode_tx_i = 8'h12; tick();
    tickin_tx = 1'b0; tcode_take = 1'b0;
    n_checks++; if (tx_tcode_in !== 8'h12 || tcode_rdy_trnsp !== 1'b1) begin n_fail++; $display("FAIL tc_both: got %h/%b want 12/1", tx_tcode_in, tcode_rdy_trnsp); end
    n_checks++; if (credit_cnt !== 6'd0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL tc_indep: got %0d/%0d want 0/0", credit_cnt, fifo_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fct_rx = 1'b1; tick(); fct_rx = 1'b0;
    for (int i = 0; i < 4; i++) write_word(9'h020 + 9'(i));
    tx_data_take = 1'b1; tick(); tick(); tx_data_take = 1'b0;
    tickin_tx = 1'b1; timecode_tx_i = 8'h44; tick(); tickin_tx = 1'b0;
    n_checks++; if (fifo_count !== 3'd2 || credit_cnt !== 6'd6 || tcode_rdy_trnsp !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %0d/%0d/%b want 2/6/1", fifo_count, credit_cnt, tcode_rdy_trnsp); end
    enable_tx = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 3'd0 || credit_cnt !== 6'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d/%0d want 0/0", fifo_count, credit_cnt); end
    n_checks++; if ({tx_data_vld, txrdy_tx, tcode_rdy_trnsp, tx_data_out, tx_tcode_in} !== 20'd0) begin n_fail++; $display("FAIL mid_async_out: got %h want 0", {tx_data_vld, txrdy_tx, tcode_rdy_trnsp, tx_data_out, tx_tcode_in}); end
    tick();
    enable_tx = 1'b1;
    tick();
    n_checks++; if (fifo_count !== 3'd0 || credit_cnt !== 6'd0 || txrdy_tx !== 1'b1) begin n_fail++; $display("FAIL mid_release: got %0d/%0d/%b want 0/0/1", fifo_count, credit_cnt, txrdy_tx); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_no_credit();
    test_full_wr_take();
    test_credit_overflow();
    test_timecode();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
